// File: rtl/link_frame_sequencer_pkg.sv
// Shared definitions for the coded-link frame sequencer.
// Holds the sequencer state encoding, default geometry of the link and a
// population-count helper used for bit-error reporting.
package link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TX    = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DEF_FRAME_W  = 28;
  localparam int DEF_SYM_W    = 2;
  localparam int DEF_CHAN_LAT = 3;
  localparam int DEF_CNT_W    = 32;

  // Widest frame the popcount helper can handle; callers zero-extend into it.
  localparam int POP_MAX_W = 256;

  function automatic logic [8:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [8:0] cnt;
    cnt = 9'd0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      cnt = cnt + 9'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/link_frame_sequencer_sym_valid_delay.sv
// Models the modulator/channel/demodulator latency for the symbol strobe.
// Ports:
//   clk - clock
//   clr - synchronous clear of every stage (flushes in-flight strobes)
//   d   - strobe in (symbol launched this cycle)
//   q   - strobe delayed by DEPTH cycles (symbol arriving this cycle)
module sym_valid_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] r_sh;

  // Shift register, stage 0 nearest the input
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sh <= {DEPTH{1'b0}};
    end else begin
      r_sh <= (r_sh << 1) | DEPTH'(d);
    end
  end

  assign q = r_sh[DEPTH-1];

endmodule

// File: rtl/link_frame_sequencer.sv
// Frame sequencer for the coded modem link.
// Accepts one frame (with optional error injection), serialises it into
// SYM_W-bit symbols, recaptures the demodulated symbols CHAN_LAT cycles
// later, and presents the rebuilt frame with its bit-error count.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid/in_ready/in_data - frame input handshake
//   err_en, err_mask         - injection control, sampled at acceptance
//   sym_o, sym_o_valid       - symbols to the modulator
//   sym_i                    - symbols from the demodulator
//   out_valid/out_ready/out_data, out_err_bits - received frame output
//   total_err_bits, frame_cnt, clear_stats     - cumulative statistics
module link_frame_sequencer
  import link_pkg::*;
#(
  parameter int FRAME_W  = DEF_FRAME_W,
  parameter int SYM_W    = DEF_SYM_W,
  parameter int CHAN_LAT = DEF_CHAN_LAT,
  parameter int CNT_W    = DEF_CNT_W,
  localparam int ERR_W   = $clog2(FRAME_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] in_data,
  input  logic               err_en,
  input  logic [FRAME_W-1:0] err_mask,
  output logic [SYM_W-1:0]   sym_o,
  output logic               sym_o_valid,
  input  logic [SYM_W-1:0]   sym_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] out_data,
  output logic [ERR_W-1:0]   out_err_bits,
  output logic [CNT_W-1:0]   total_err_bits,
  output logic [15:0]        frame_cnt,
  input  logic               clear_stats
);

  localparam int NSYM  = FRAME_W / SYM_W;
  localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic               w_in_ready, w_accept, w_deliver;
  logic               w_last_tx, w_last_rx, w_cap_valid;
  logic [FRAME_W-1:0] w_tx_in, w_rx_full;
  logic [SUM_W-1:0]   w_sum;

  logic [FRAME_W-1:0] r_clean, r_tx_sh, r_rx, r_out_data;
  logic [IDX_W-1:0]   r_tx_idx, r_rx_idx;
  logic [SYM_W-1:0]   r_sym_o;
  logic               r_sym_o_valid, r_out_valid;
  logic [ERR_W-1:0]   r_out_err;
  logic [CNT_W-1:0]   r_total;
  logic [15:0]        r_frame_cnt;

  assign w_tx_in   = in_data ^ (err_en ? err_mask : {FRAME_W{1'b0}});
  // Received symbols enter at the top so symbol 0 ends up in the low bits.
  assign w_rx_full = {sym_i, r_rx[FRAME_W-1:SYM_W]};
  assign w_last_tx = (r_state == TX) && (r_tx_idx == LAST_IDX);
  assign w_last_rx = w_cap_valid && (r_rx_idx == LAST_IDX);
  assign w_sum     = {1'b0, r_total} + SUM_W'(r_out_err);

  sym_valid_delay #(.DEPTH(CHAN_LAT)) u_dly (
    .clk (clk),
    .clr (rst),
    .d   (r_sym_o_valid),
    .q   (w_cap_valid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = in_valid ? TX : IDLE;
      TX:      w_state_nxt = w_last_tx ? DRAIN : TX;
      DRAIN:   w_state_nxt = w_last_rx ? OUT : DRAIN;
      OUT: begin
        if (out_ready) begin
          w_state_nxt = in_valid ? TX : IDLE;
        end else begin
          w_state_nxt = OUT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake decode; delivery and a new acceptance may share a cycle
  always_comb begin
    w_in_ready = (r_state == IDLE) || ((r_state == OUT) && out_ready);
    w_accept   = in_valid && w_in_ready;
    w_deliver  = (r_state == OUT) && out_ready;
  end

  // Transmit path: latch frame, shift out one symbol per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clean       <= {FRAME_W{1'b0}};
      r_tx_sh       <= {FRAME_W{1'b0}};
      r_tx_idx      <= {IDX_W{1'b0}};
      r_sym_o       <= {SYM_W{1'b0}};
      r_sym_o_valid <= 1'b0;
    end else if (w_accept) begin
      r_clean       <= in_data;
      r_tx_sh       <= w_tx_in >> SYM_W;
      r_sym_o       <= w_tx_in[SYM_W-1:0];
      r_sym_o_valid <= 1'b1;
      r_tx_idx      <= {IDX_W{1'b0}};
    end else if (r_state == TX) begin
      if (w_last_tx) begin
        r_sym_o_valid <= 1'b0;
      end else begin
        r_sym_o  <= r_tx_sh[SYM_W-1:0];
        r_tx_sh  <= r_tx_sh >> SYM_W;
        r_tx_idx <= r_tx_idx + IDX_W'(1);
      end
    end
  end

  // Receive path: capture on the delayed strobe, publish on the last symbol
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx        <= {FRAME_W{1'b0}};
      r_rx_idx    <= {IDX_W{1'b0}};
      r_out_data  <= {FRAME_W{1'b0}};
      r_out_err   <= {ERR_W{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      if (w_cap_valid) begin
        r_rx     <= w_rx_full;
        r_rx_idx <= w_last_rx ? {IDX_W{1'b0}} : (r_rx_idx + IDX_W'(1));
      end
      if (w_last_rx) begin
        r_out_data <= w_rx_full;
        r_out_err  <= ERR_W'(popcount(POP_MAX_W'(r_clean ^ w_rx_full)));
      end
      r_out_valid <= (w_state_nxt == OUT);
    end
  end

  // Statistics: clear wins over a same-cycle delivery; error sum saturates
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      r_total     <= {CNT_W{1'b0}};
      r_frame_cnt <= 16'd0;
    end else if (w_deliver) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
      r_total     <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end
  end

  assign in_ready       = w_in_ready;
  assign sym_o          = r_sym_o;
  assign sym_o_valid    = r_sym_o_valid;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_err_bits   = r_out_err;
  assign total_err_bits = r_total;
  assign frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_link_frame_sequencer.sv
// Self-checking bench for link_frame_sequencer: a default-geometry instance
// driven from a vector table with a scoreboard, plus a 16-QAM instance.
module tb_link_frame_sequencer;

  typedef struct {
    logic [27:0] data;
    logic        en;
    logic [27:0] mask;
    logic [27:0] exp_data;
    logic [4:0]  exp_err;
  } vec_t;

  logic        clk, rst;
  // Instance A: FRAME_W=28, SYM_W=2, CHAN_LAT=3
  logic        in_valid, in_ready, err_en, out_valid, out_ready, clear_stats;
  logic        sym_o_valid;
  logic [27:0] in_data, err_mask, out_data;
  logic [1:0]  sym_o, sym_i, lb0, lb1, lb2;
  logic [4:0]  out_err_bits;
  logic [31:0] total_err_bits;
  logic [15:0] frame_cnt;
  // Instance B: FRAME_W=32, SYM_W=4, CHAN_LAT=1, CNT_W=5
  logic        b_in_valid, b_in_ready, b_err_en, b_out_valid, b_out_ready;
  logic        b_sym_o_valid, b_clear;
  logic [31:0] b_in_data, b_err_mask, b_out_data;
  logic [3:0]  b_sym_o, b_sym_i;
  logic [5:0]  b_err_bits;
  logic [4:0]  b_total;
  logic [15:0] b_frame_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  vec_t        vecs[7];
  vec_t        sb[$];
  logic [27:0] cur_tx;
  logic [4:0]  last_err;
  logic [15:0] m_cnt;
  logic [31:0] m_total;

  link_frame_sequencer u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .err_en(err_en), .err_mask(err_mask),
    .sym_o(sym_o), .sym_o_valid(sym_o_valid), .sym_i(sym_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err_bits(out_err_bits), .total_err_bits(total_err_bits),
    .frame_cnt(frame_cnt), .clear_stats(clear_stats)
  );

  link_frame_sequencer #(.FRAME_W(32), .SYM_W(4), .CHAN_LAT(1), .CNT_W(5)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .err_en(b_err_en), .err_mask(b_err_mask),
    .sym_o(b_sym_o), .sym_o_valid(b_sym_o_valid), .sym_i(b_sym_i),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_err_bits(b_err_bits), .total_err_bits(b_total),
    .frame_cnt(b_frame_cnt), .clear_stats(b_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel loopback: 3-cycle delay for A, 1-cycle delay for B
  always @(posedge clk) begin
    if (rst) begin
      lb0 <= 2'd0; lb1 <= 2'd0; lb2 <= 2'd0; b_sym_i <= 4'd0;
    end else begin
      lb0 <= sym_o; lb1 <= lb0; lb2 <= lb1; b_sym_i <= b_sym_o;
    end
  end
  assign sym_i = lb2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a frame at a negedge; returns at the negedge of cycle 1
  task automatic start_frame(input vec_t v);
    in_valid = 1'b1; in_data = v.data; err_en = v.en; err_mask = v.mask;
    sb.push_back(v);
    cur_tx = v.data ^ (v.en ? v.mask : 28'h0);
    #1;
    check("in_ready_offer", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = 28'h0; err_en = 1'b0; err_mask = 28'h0;
    out_ready = 1'b0; clear_stats = 1'b0;
  endtask

  // Follow the symbol stream and wait (bounded) for out_valid
  task automatic wait_out(input int exp_lat);
    int   lat;
    vec_t e;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c <= 14) begin
        check("sym_o_valid", sym_o_valid, 1'b1);
        check("sym_o", sym_o, cur_tx[(c-1)*2 +: 2]);
      end else if (c == 15) begin
        check("sym_o_valid_low", sym_o_valid, 1'b0);
      end
      if (out_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check("out_latency", lat, exp_lat);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      check("out_data", out_data, e.exp_data);
      check("out_err_bits", out_err_bits, e.exp_err);
      last_err = e.exp_err;
    end
  endtask

  task automatic model_deliver(input bit clr);
    longint s;
    if (clr) begin
      m_cnt = 16'd0; m_total = 32'd0;
    end else begin
      m_cnt = m_cnt + 16'd1;
      s = longint'(m_total) + longint'(last_err);
      m_total = (s > 64'h0FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    end
  endtask

  task automatic deliver(input bit clr);
    out_ready = 1'b1; clear_stats = clr;
    model_deliver(clr);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; clear_stats = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("frame_cnt", frame_cnt, m_cnt);
    check("total_err_bits", total_err_bits, m_total);
    check("in_ready_idle", in_ready, 1'b1);
  endtask

  // Run one frame on instance B and deliver it
  task automatic b_run(input logic [31:0] d, input logic en, input logic [31:0] m,
                       input logic [5:0] exp_err, input logic [4:0] exp_total,
                       input logic [15:0] exp_cnt);
    logic [31:0] tx;
    int lat;
    tx = d ^ (en ? m : 32'h0);
    b_in_valid = 1'b1; b_in_data = d; b_err_en = en; b_err_mask = m;
    #1;
    check("b_in_ready", b_in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0; b_err_en = 1'b0;
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c <= 8) begin
        check("b_sym_o_valid", b_sym_o_valid, 1'b1);
        check("b_sym_o", b_sym_o, tx[(c-1)*4 +: 4]);
      end
      if (b_out_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check("b_out_latency", lat, 10);
    check("b_out_data", b_out_data, tx);
    check("b_out_err_bits", b_err_bits, exp_err);
    b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_out_ready = 1'b0;
    check("b_frame_cnt", b_frame_cnt, exp_cnt);
    check("b_total", b_total, exp_total);
  endtask

  initial begin
    logic        saw;
    logic [3:0]  b_order [8];
    logic [31:0] b_word;

    vecs[0] = '{28'h0A5C3F1, 1'b0, 28'h0000000, 28'h0A5C3F1, 5'd0};
    vecs[1] = '{28'h0A5C3F1, 1'b1, 28'hF000000, 28'hFA5C3F1, 5'd4};
    vecs[2] = '{28'hFFFFFFF, 1'b1, 28'h0000007, 28'hFFFFFF8, 5'd3};
    vecs[3] = '{28'h1234567, 1'b0, 28'hFFFFFFF, 28'h1234567, 5'd0};
    vecs[4] = '{28'h0000000, 1'b1, 28'hFFFFFFF, 28'hFFFFFFF, 5'd28};
    vecs[5] = '{28'h5555555, 1'b1, 28'h8000001, 28'hD555554, 5'd2};
    vecs[6] = '{28'h0000000, 1'b1, 28'h000001F, 28'h000001F, 5'd5};

    rst = 1'b1; in_valid = 1'b0; in_data = 28'h0; err_en = 1'b0; err_mask = 28'h0;
    out_ready = 1'b0; clear_stats = 1'b0;
    b_in_valid = 1'b0; b_in_data = 32'h0; b_err_en = 1'b0; b_err_mask = 32'h0;
    b_out_ready = 1'b0; b_clear = 1'b0;
    m_cnt = 16'd0; m_total = 32'd0; last_err = 5'd0; cur_tx = 28'h0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_sym_o", sym_o, 2'd0);
    check("rst_sym_o_valid", sym_o_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 28'h0);
    check("rst_total", total_err_bits, 32'd0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_b_in_ready", b_in_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames through the loopback
    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i]);
      wait_out(18);
      deliver(1'b0);
    end

    // Backpressure: hold out_ready low, then deliver and accept together
    start_frame(vecs[2]);
    wait_out(18);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_out_data", out_data, vecs[2].exp_data);
      check("hold_out_err", out_err_bits, vecs[2].exp_err);
      check("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    model_deliver(1'b0);
    start_frame(vecs[3]);
    check("b2b_out_valid", out_valid, 1'b0);
    check("b2b_frame_cnt", frame_cnt, m_cnt);
    check("b2b_total", total_err_bits, m_total);
    wait_out(18);
    deliver(1'b0);

    // Reset in cycle 7 of TX
    start_frame(vecs[4]);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_sym_o", sym_o, 2'd0);
    check("mid_rst_sym_o_valid", sym_o_valid, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, 28'h0);
    check("mid_rst_out_err", out_err_bits, 5'd0);
    check("mid_rst_total", total_err_bits, 32'd0);
    check("mid_rst_frame_cnt", frame_cnt, 16'd0);
    rst = 1'b0;
    sb.delete();
    m_cnt = 16'd0; m_total = 32'd0;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      saw = saw | out_valid;
    end
    check("no_late_out_valid", saw, 1'b0);
    check("no_late_capture", out_data, 28'h0);

    // Accumulate 3 + 5, then clear together with a third delivery
    start_frame(vecs[2]); wait_out(18); deliver(1'b0);
    start_frame(vecs[6]); wait_out(18); deliver(1'b0);
    check("stats_sum_8", total_err_bits, 32'd8);
    start_frame(vecs[0]); wait_out(18); deliver(1'b1);
    check("stats_cleared_total", total_err_bits, 32'd0);
    check("stats_cleared_cnt", frame_cnt, 16'd0);

    // 16-QAM instance: explicit symbol order, then error-sum saturation
    b_order = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
    b_word = 32'h1234ABCD;
    for (int k = 0; k < 8; k++) begin
      check("b_order_table", b_word[k*4 +: 4], b_order[k]);
    end
    b_run(32'h1234ABCD, 1'b0, 32'h0, 6'd0, 5'd0, 16'd1);
    b_run(32'h00000000, 1'b1, 32'hFFFFFFFF, 6'd32, 5'h1F, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
